// File: rtl/avr_prefetch_queue_if.sv
// Program-memory read bus used by the instruction prefetch queue.
//
// The prefetcher is the master. It holds pmem_addr stable while pmem_req is
// high and waits for pmem_ack. The memory is the slave. It returns pmem_data
// in the same cycle as pmem_ack.
//
// Signals:
//   pmem_addr  AW   word address of the read (master -> slave)
//   pmem_req   1    read request (master -> slave)
//   pmem_ack   1    read complete, pmem_data valid (slave -> master)
//   pmem_data  16   raw program word, little-endian byte order (slave -> master)
interface avr_prefetch_queue_if #(
   parameter int AW = 16
);
   logic [AW-1:0] pmem_addr;
   logic          pmem_req;
   logic          pmem_ack;
   logic [15:0]   pmem_data;

   modport master (
      output pmem_addr,
      output pmem_req,
      input  pmem_ack,
      input  pmem_data
   );

   modport slave (
      input  pmem_addr,
      input  pmem_req,
      output pmem_ack,
      output pmem_data
   );
endinterface

// File: rtl/avr_prefetch_queue.sv
// Instruction prefetch stage placed in front of avr_cpu.
//
// The block fetches program words ahead of execution from a program memory
// with variable latency. It buffers up to DEPTH byte-swapped words, and tags
// each one with its word address. The oldest word is shown to the CPU as
// cur_instr/current_pc. The CPU consumes words, redirects the fetch stream,
// or holds, using pc_src and stall.
//
// Ports:
//   CLK          clock, all state changes on the rising edge
//   RST          synchronous, active-high reset
//   pc_src[2:0]  000 restart, 001 hold, 010 consume 1, 011 consume 2,
//                100 relative jump, 101 absolute jump, 11x hold
//   jmp[AW-1:0]  jump target (101) or signed offset (100)
//   stall        CPU is not consuming this cycle
//   cur_instr    head word, byte-swapped, 0 when the queue is empty
//   current_pc   address of the head word, or the fetch address when empty
//   instr_valid  queue is non-empty
//   pmem         program-memory bus (master side)
//
// Optional feature macro AVR_PF_NEXT_WORD_EN:
//   Adds the ports next_instr and next_valid, which show the entry after the
//   head. With the macro, pc_src 011 pops two words, but only when two are
//   present. Without the macro, 011 behaves like 010.
module avr_prefetch_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 16
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic [2:0]    pc_src,
   input  logic [AW-1:0] jmp,
   input  logic          stall,
   output logic [15:0]   cur_instr,
   output logic [AW-1:0] current_pc,
   output logic          instr_valid,
`ifdef AVR_PF_NEXT_WORD_EN
   output logic [15:0]   next_instr,
   output logic          next_valid,
`endif
   avr_prefetch_queue_if.master pmem
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

   state_t        state_q;
   logic [15:0]   mem_q   [DEPTH];
   logic [AW-1:0] pcTag_q [DEPTH];
   logic [PW-1:0] rdPtr_q, rdPtr_d;
   logic [PW-1:0] wrPtr_q, wrPtr_d;
   logic [PW:0]   count_q, count_d;
   logic [AW-1:0] fetchPc_q;
   logic [AW-1:0] pmemAddr_q;
   logic          pmemReq_q;

   logic          redirect;
   logic          push;
   logic [PW:0]   popCount;
   logic [AW-1:0] target;
   logic [AW-1:0] headPc;

   // Head-of-queue view. It reads the registered entries directly, so a word
   // is visible in the cycle right after it is pushed.
   always_comb begin
      instr_valid = (count_q != '0);
      headPc      = instr_valid ? pcTag_q[rdPtr_q] : fetchPc_q;
      current_pc  = headPc;
      cur_instr   = instr_valid ? mem_q[rdPtr_q] : 16'h0000;
   end

`ifdef AVR_PF_NEXT_WORD_EN
   logic [PW-1:0] nextPtr;

   // The second entry is shown so the CPU can decode two-word instructions.
   always_comb begin
      nextPtr    = rdPtr_q + PW'(1);
      next_valid = (count_q >= (PW+1)'(2));
      next_instr = next_valid ? mem_q[nextPtr] : 16'h0000;
   end
`endif

   // Decode the CPU control. A redirect wins over everything else and
   // flushes the queue. A pop happens only when the CPU is not stalled and
   // a word is present. A push needs an ack on a request that is still live.
   always_comb begin
      redirect = (pc_src == 3'b000) || (pc_src == 3'b100) || (pc_src == 3'b101);
      case (pc_src)
         3'b000:  target = '0;
         3'b100:  target = headPc + jmp;
         default: target = jmp;
      endcase

      popCount = '0;
      if (!redirect && !stall && instr_valid) begin
         if (pc_src == 3'b010) begin
            popCount = (PW+1)'(1);
         end else if (pc_src == 3'b011) begin
`ifdef AVR_PF_NEXT_WORD_EN
            if (count_q >= (PW+1)'(2)) begin
               popCount = (PW+1)'(2);
            end
`else
            popCount = (PW+1)'(1);
`endif
         end
      end

      push = (state_q == WAIT) && pmem.pmem_ack && !redirect;

      if (redirect) begin
         count_d = '0;
         rdPtr_d = '0;
         wrPtr_d = '0;
      end else begin
         count_d = count_q + (PW+1)'(push) - popCount;
         rdPtr_d = rdPtr_q + PW'(popCount);
         wrPtr_d = wrPtr_q + PW'(push);
      end
   end

   // Request FSM and FIFO storage. Only one read is outstanding at a time.
   // The request address never changes while req is high and no ack has
   // arrived. If a redirect arrives during an outstanding read, the state
   // moves to DISCARD, so the stale word is dropped when it finally arrives.
   // After that, the next read is issued at the new fetch address.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         rdPtr_q    <= '0;
         wrPtr_q    <= '0;
         count_q    <= '0;
         fetchPc_q  <= '0;
         pmemAddr_q <= '0;
         pmemReq_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         rdPtr_q <= rdPtr_d;
         wrPtr_q <= wrPtr_d;
         if (push) begin
            mem_q[wrPtr_q]   <= {pmem.pmem_data[7:0], pmem.pmem_data[15:8]};
            pcTag_q[wrPtr_q] <= fetchPc_q;
         end

         case (state_q)
            IDLE: begin
               if (redirect) begin
                  fetchPc_q <= target;
               end else if (count_d < DEPTH_C) begin
                  state_q    <= WAIT;
                  pmemReq_q  <= 1'b1;
                  pmemAddr_q <= fetchPc_q;
               end
            end
            WAIT: begin
               if (pmem.pmem_ack) begin
                  if (redirect) begin
                     fetchPc_q  <= target;
                     pmemAddr_q <= target;
                  end else begin
                     fetchPc_q <= fetchPc_q + AW'(1);
                     if (count_d < DEPTH_C) begin
                        pmemAddr_q <= fetchPc_q + AW'(1);
                     end else begin
                        state_q   <= IDLE;
                        pmemReq_q <= 1'b0;
                     end
                  end
               end else if (redirect) begin
                  fetchPc_q <= target;
                  state_q   <= DISCARD;
               end
            end
            DISCARD: begin
               if (redirect) begin
                  fetchPc_q <= target;
               end
               if (pmem.pmem_ack) begin
                  state_q    <= WAIT;
                  pmemAddr_q <= redirect ? target : fetchPc_q;
               end
            end
            default: begin
               state_q   <= IDLE;
               pmemReq_q <= 1'b0;
            end
         endcase
      end
   end

   assign pmem.pmem_addr = pmemAddr_q;
   assign pmem.pmem_req  = pmemReq_q;

endmodule

// File: tb/tb_avr_prefetch_queue.sv
// Self-checking bench for avr_prefetch_queue.
//
// The bench drives the CPU controls and acts as the program memory. It keeps
// a reference model of the queue as a list of {address, word} entries. The
// outstanding memory read is modelled as live or stale. Outputs are compared
// on every falling edge.
module tb_avr_prefetch_queue;

   localparam int DEPTH = 4;
   localparam int AW    = 16;

   typedef struct {
      logic [15:0] pc;
      logic [15:0] word;
   } entry_t;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [2:0]    pc_src = 3'b001;
   logic [AW-1:0] jmp = '0;
   logic          stall = 1'b0;
   logic [15:0]   cur_instr;
   logic [AW-1:0] current_pc;
   logic          instr_valid;
`ifdef AVR_PF_NEXT_WORD_EN
   logic [15:0]   next_instr;
   logic          next_valid;
`endif

   avr_prefetch_queue_if #(.AW(AW)) pmemIf();

   avr_prefetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .pc_src      (pc_src),
      .jmp         (jmp),
      .stall       (stall),
      .cur_instr   (cur_instr),
      .current_pc  (current_pc),
      .instr_valid (instr_valid),
`ifdef AVR_PF_NEXT_WORD_EN
      .next_instr  (next_instr),
      .next_valid  (next_valid),
`endif
      .pmem        (pmemIf)
   );

   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   entry_t      mq[$];
   logic [15:0] mFetchPc;
   logic [15:0] mAddr;
   bit          mReq;
   bit          mStale;

   // Every comparison in the bench goes through this task.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic modelReset();
      mq.delete();
      mFetchPc = '0;
      mAddr    = '0;
      mReq     = 1'b0;
      mStale   = 1'b0;
   endtask

   // Advance the reference model by one clock, using the inputs sampled at
   // that edge. Addresses wrap modulo 2^16.
   task automatic modelStep(input logic [2:0] src, input logic [15:0] j,
                            input logic st, input logic a, input logic [15:0] d);
      bit          redirect;
      logic [15:0] headPc;
      logic [15:0] target;
      int          popN;
      entry_t      e;
      redirect = (src == 3'd0) || (src == 3'd4) || (src == 3'd5);
      headPc   = (mq.size() != 0) ? mq[0].pc : mFetchPc;
      target   = (src == 3'd0) ? 16'h0000 : (src == 3'd4) ? 16'(headPc + j) : j;
      if (redirect) begin
         mq.delete();
         mFetchPc = target;
         if (mReq) begin
            if (a) begin
               mAddr  = target;
               mStale = 1'b0;
            end else begin
               mStale = 1'b1;
            end
         end
      end else begin
         popN = 0;
         if (!st && mq.size() != 0) begin
            if (src == 3'd2) popN = 1;
`ifdef AVR_PF_NEXT_WORD_EN
            if (src == 3'd3) popN = (mq.size() >= 2) ? 2 : 0;
`else
            if (src == 3'd3) popN = 1;
`endif
         end
         for (int i = 0; i < popN; i++) void'(mq.pop_front());
         if (mReq && mStale) begin
            if (a) begin
               mStale = 1'b0;
               mAddr  = mFetchPc;
            end
         end else if (mReq && a) begin
            e.pc   = mFetchPc;
            e.word = {d[7:0], d[15:8]};
            mq.push_back(e);
            mFetchPc = mFetchPc + 16'd1;
            if (mq.size() < DEPTH) mAddr = mFetchPc;
            else                   mReq  = 1'b0;
         end else if (!mReq && mq.size() < DEPTH) begin
            mReq  = 1'b1;
            mAddr = mFetchPc;
         end
      end
   endtask

   task automatic compareModel();
      checkOutput("instr_valid", 32'(instr_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
         checkOutput("cur_instr", 32'(cur_instr), 32'(mq[0].word));
         checkOutput("current_pc", 32'(current_pc), 32'(mq[0].pc));
      end else begin
         checkOutput("cur_instr", 32'(cur_instr), 32'h0);
         checkOutput("current_pc", 32'(current_pc), 32'(mFetchPc));
      end
      checkOutput("pmem_req", 32'(pmemIf.pmem_req), 32'(mReq));
      checkOutput("pmem_addr", 32'(pmemIf.pmem_addr), 32'(mAddr));
`ifdef AVR_PF_NEXT_WORD_EN
      checkOutput("next_valid", 32'(next_valid), 32'(mq.size() >= 2));
      if (mq.size() >= 2) checkOutput("next_instr", 32'(next_instr), 32'(mq[1].word));
      else                checkOutput("next_instr", 32'(next_instr), 32'h0);
`endif
   endtask

   // Drive one cycle of stimulus from a falling edge, clock it, step the
   // model, then compare everything on the next falling edge.
   task automatic applyStimulus(input logic [2:0] src, input logic [15:0] j,
                                input logic st, input logic a, input logic [15:0] d);
      pc_src           = src;
      jmp              = j;
      stall            = st;
      pmemIf.pmem_ack  = a;
      pmemIf.pmem_data = d;
      @(posedge CLK);
      if (RST) modelReset();
      else     modelStep(src, j, st, a, d);
      @(negedge CLK);
      compareModel();
   endtask

   task automatic doReset();
      RST = 1'b1;
      applyStimulus(3'b001, 16'h0, 1'b0, 1'b0, 16'h0);
      RST = 1'b0;
   endtask

   initial begin
      int ackPct;
      int r;
      logic [2:0] src;
      pmemIf.pmem_ack  = 1'b0;
      pmemIf.pmem_data = 16'h0;
      modelReset();
      @(negedge CLK);

      // Reset state followed by the first fetch with ack every cycle.
      doReset();
      checkOutput("rst_req", 32'(pmemIf.pmem_req), 32'h0);
      checkOutput("rst_valid", 32'(instr_valid), 32'h0);
      applyStimulus(3'b001, 16'h0, 1'b0, 1'b1, 16'h0CE0);
      checkOutput("t1_req", 32'(pmemIf.pmem_req), 32'h1);
      checkOutput("t1_addr", 32'(pmemIf.pmem_addr), 32'h0);
      applyStimulus(3'b001, 16'h0, 1'b0, 1'b1, 16'h0CE0);
      checkOutput("t1_valid", 32'(instr_valid), 32'h1);
      checkOutput("t1_instr", 32'(cur_instr), 32'hE00C);
      checkOutput("t1_pc", 32'(current_pc), 32'h0);

      // Under stall the queue fills to DEPTH and the fetch stops. One
      // consume then restarts the fetch at address 4.
      doReset();
      for (int i = 0; i < 8; i++) applyStimulus(3'b010, 16'h0, 1'b1, 1'b1, 16'(i));
      checkOutput("t2_req_off", 32'(pmemIf.pmem_req), 32'h0);
      checkOutput("t2_last_addr", 32'(pmemIf.pmem_addr), 32'h3);
      applyStimulus(3'b010, 16'h0, 1'b0, 1'b1, 16'h0);
      checkOutput("t2_req_on", 32'(pmemIf.pmem_req), 32'h1);
      checkOutput("t2_addr4", 32'(pmemIf.pmem_addr), 32'h4);
      checkOutput("t2_head", 32'(current_pc), 32'h1);

      // Absolute jump while a read is outstanding and the ack is late.
      doReset();
      applyStimulus(3'b001, 16'h0, 1'b0, 1'b0, 16'h0);
      applyStimulus(3'b101, 16'h0040, 1'b0, 1'b0, 16'h0);
      checkOutput("t3_hold", 32'(pmemIf.pmem_addr), 32'h0);
      applyStimulus(3'b001, 16'h0, 1'b0, 1'b0, 16'h0);
      applyStimulus(3'b001, 16'h0, 1'b0, 1'b0, 16'h0);
      checkOutput("t3_hold2", 32'(pmemIf.pmem_addr), 32'h0);
      applyStimulus(3'b001, 16'h0, 1'b0, 1'b1, 16'hDEAD);
      checkOutput("t3_newaddr", 32'(pmemIf.pmem_addr), 32'h40);
      checkOutput("t3_dropped", 32'(instr_valid), 32'h0);
      applyStimulus(3'b001, 16'h0, 1'b0, 1'b1, 16'h1234);
      checkOutput("t3_headpc", 32'(current_pc), 32'h40);

      // Relative jump with a negative offset, then address wrap at 0xFFFF.
      doReset();
      applyStimulus(3'b101, 16'h0010, 1'b0, 1'b0, 16'h0);
      applyStimulus(3'b001, 16'h0, 1'b0, 1'b0, 16'h0);
      applyStimulus(3'b001, 16'h0, 1'b0, 1'b1, 16'hAAAA);
      checkOutput("t4_head10", 32'(current_pc), 32'h10);
      applyStimulus(3'b100, 16'hFFF8, 1'b0, 1'b0, 16'h0);
      checkOutput("t4_flush", 32'(instr_valid), 32'h0);
      applyStimulus(3'b001, 16'h0, 1'b0, 1'b1, 16'h0);
      checkOutput("t4_addr8", 32'(pmemIf.pmem_addr), 32'h8);
      doReset();
      applyStimulus(3'b101, 16'hFFFF, 1'b0, 1'b0, 16'h0);
      applyStimulus(3'b001, 16'h0, 1'b0, 1'b0, 16'h0);
      checkOutput("t4_addrFFFF", 32'(pmemIf.pmem_addr), 32'hFFFF);
      applyStimulus(3'b001, 16'h0, 1'b0, 1'b1, 16'h5A5A);
      checkOutput("t4_wrap", 32'(pmemIf.pmem_addr), 32'h0);

      // Push and pop in the same cycle while the queue holds two words.
      doReset();
      applyStimulus(3'b001, 16'h0, 1'b0, 1'b0, 16'h0);
      applyStimulus(3'b001, 16'h0, 1'b0, 1'b1, 16'h1122);
      applyStimulus(3'b001, 16'h0, 1'b0, 1'b1, 16'h3344);
      applyStimulus(3'b010, 16'h0, 1'b0, 1'b1, 16'h5566);
      checkOutput("t5_advance", 32'(cur_instr), 32'h4433);
      applyStimulus(3'b011, 16'h0, 1'b0, 1'b0, 16'h0);
`ifdef AVR_PF_NEXT_WORD_EN
      checkOutput("t5_pop2", 32'(instr_valid), 32'h0);
`else
      checkOutput("t5_pop1", 32'(cur_instr), 32'h6655);
`endif

      // Reset in the middle of a request, followed by a late ack.
      applyStimulus(3'b001, 16'h0, 1'b1, 1'b0, 16'h0);
      RST = 1'b1;
      applyStimulus(3'b001, 16'h0, 1'b0, 1'b1, 16'hBEEF);
      RST = 1'b0;
      checkOutput("t6_req", 32'(pmemIf.pmem_req), 32'h0);
      checkOutput("t6_valid", 32'(instr_valid), 32'h0);
      applyStimulus(3'b001, 16'h0, 1'b0, 1'b1, 16'hBEEF);
      checkOutput("t6_late_ack", 32'(instr_valid), 32'h0);

      // Random traffic. The ack density changes every 200 cycles.
      doReset();
      for (int i = 0; i < 3000; i++) begin
         ackPct = ((i / 200) % 3 == 0) ? 100 : ((i / 200) % 3 == 1) ? 50 : 20;
         r = int'($urandom_range(0, 99));
         if (r < 2)       src = 3'b000;
         else if (r < 5)  src = 3'b100;
         else if (r < 8)  src = 3'b101;
         else if (r < 12) src = 3'(6 + $urandom_range(0, 1));
         else if (r < 55) src = 3'b010;
         else if (r < 75) src = 3'b011;
         else             src = 3'b001;
         if ($urandom_range(0, 499) == 0) begin
            doReset();
         end else begin
            applyStimulus(src, 16'($urandom), ($urandom_range(0, 3) == 0),
                          (int'($urandom_range(0, 99)) < ackPct), 16'($urandom));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
